// File: rtl/pipe_stage.sv
// Elastic pipeline stage: in-order buffer of DEPTH entries with valid/ready
// handshakes on both sides, plus a saturating downstream-stall counter.
module pipe_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [2:0]       count,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]        DEPTH_C  = 3'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Explicit wrap so a non-power-of-two depth never indexes past the last entry.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready depends only on occupancy, so a full stage never accepts on the cycle it drains.
  assign s_ready = !rst && !flush && (count < DEPTH_C);
  assign m_valid = (count != 3'd0);
  assign m_data  = mem[rd_ptr];
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= 3'd0;
      stall_cnt <= '0;
    end else begin
      if (m_valid && !m_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= 3'd0;
      end else begin
        if (push) begin
          wr_ptr <= next_ptr(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= next_ptr(rd_ptr);
        end
        if (push && !pop) begin
          count <= count + 3'd1;
        end else if (pop && !push) begin
          count <= count - 3'd1;
        end
      end
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: directed vector table (DEPTH=2), DEPTH=1 throughput and
// saturating stall counter (CNT_W=2), and randomized DEPTH=3 traffic vs a queue model.
module tb_pipe_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic       a_flush = 1'b0, a_sv = 1'b0, a_mr = 1'b0;
  logic       a_sr, a_mv;
  logic [7:0] a_sd = 8'h00, a_md;
  logic [2:0] a_cnt;
  logic [15:0] a_stall;

  // DEPTH=1, CNT_W=2 instance
  logic       b_flush = 1'b0, b_sv = 1'b0, b_mr = 1'b0;
  logic       b_sr, b_mv;
  logic [7:0] b_sd = 8'h00, b_md;
  logic [2:0] b_cnt;
  logic [1:0] b_stall;

  // DEPTH=3 instance
  logic       c_flush = 1'b0, c_sv = 1'b0, c_mr = 1'b0;
  logic       c_sr, c_mv;
  logic [7:0] c_sd = 8'h00, c_md;
  logic [2:0] c_cnt;
  logic [15:0] c_stall;

  pipe_stage #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst(rst), .flush(a_flush), .s_valid(a_sv), .s_ready(a_sr),
    .s_data(a_sd), .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md),
    .count(a_cnt), .stall_cnt(a_stall));

  pipe_stage #(.WIDTH(8), .DEPTH(1), .CNT_W(2)) u_d1 (
    .clk(clk), .rst(rst), .flush(b_flush), .s_valid(b_sv), .s_ready(b_sr),
    .s_data(b_sd), .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md),
    .count(b_cnt), .stall_cnt(b_stall));

  pipe_stage #(.WIDTH(8), .DEPTH(3), .CNT_W(16)) u_d3 (
    .clk(clk), .rst(rst), .flush(c_flush), .s_valid(c_sv), .s_ready(c_sr),
    .s_data(c_sd), .m_valid(c_mv), .m_ready(c_mr), .m_data(c_md),
    .count(c_cnt), .stall_cnt(c_stall));

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic        sv;
    logic [7:0]  sd;
    logic        mr;
    logic        fl;
    logic        sr;
    logic        mv;
    logic [7:0]  md;
    logic [2:0]  cnt;
    logic [15:0] stall;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic sv, input logic [7:0] sd, input logic mr,
                              input logic fl, input logic sr, input logic mv,
                              input logic [7:0] md, input logic [2:0] cnt,
                              input logic [15:0] stall);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.fl = fl; v.sr = sr;
    v.mv = mv; v.md = md; v.cnt = cnt; v.stall = stall;
    return v;
  endfunction

  // Leaves rst low at a falling edge so the caller can transfer in that very cycle.
  task automatic do_reset();
    rst = 1'b1;
    a_sv = 1'b0; a_mr = 1'b0; a_flush = 1'b0;
    b_sv = 1'b0; b_mr = 1'b0; b_flush = 1'b0;
    c_sv = 1'b0; c_mr = 1'b0; c_flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst d2 s_ready", 32'(a_sr), 32'd0);
    chk("rst d1 s_ready", 32'(b_sr), 32'd0);
    chk("rst d3 s_ready", 32'(c_sr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] q[$];
  int mstall;
  int nin, nout, cyc;
  int exp_stall3[6] = '{1, 2, 3, 3, 3, 3};
  logic exp_sr, exp_mv;

  initial begin
    // sv  sd     mr    fl    sr    mv    md     cnt   stall
    tbl.push_back(mk(1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 16'd0));
    tbl.push_back(mk(1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd1, 16'd0));
    tbl.push_back(mk(1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 3'd1, 16'd0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 3'd1, 16'd0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 16'd0));
    tbl.push_back(mk(1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'd2, 16'd1));
    tbl.push_back(mk(1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 3'd2, 16'd2));
    tbl.push_back(mk(1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 3'd1, 16'd2));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h13, 3'd1, 16'd2));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 16'd2));
    tbl.push_back(mk(1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 16'd2));
    tbl.push_back(mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h21, 3'd1, 16'd2));
    tbl.push_back(mk(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 8'h21, 3'd2, 16'd3));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 16'd3));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 16'd3));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      a_sv = tbl[i].sv; a_sd = tbl[i].sd; a_mr = tbl[i].mr; a_flush = tbl[i].fl;
      #1;
      chk($sformatf("v%0d s_ready", i), 32'(a_sr), 32'(tbl[i].sr));
      chk($sformatf("v%0d m_valid", i), 32'(a_mv), 32'(tbl[i].mv));
      chk($sformatf("v%0d count", i), 32'(a_cnt), 32'(tbl[i].cnt));
      chk($sformatf("v%0d stall_cnt", i), 32'(a_stall), 32'(tbl[i].stall));
      if (tbl[i].mv) chk($sformatf("v%0d m_data", i), 32'(a_md), 32'(tbl[i].md));
      @(negedge clk);
    end
    a_sv = 1'b0; a_mr = 1'b0; a_flush = 1'b0;

    // DEPTH=1: eight payloads with continuous valid/ready take two cycles each
    do_reset();
    nin = 0; nout = 0; cyc = 0;
    b_mr = 1'b1;
    while (nout < 8 && cyc < 40) begin
      b_sv = (nin < 8);
      b_sd = 8'(nin + 1);
      #1;
      if (b_mv && b_mr) begin
        chk($sformatf("d1 out%0d", nout), 32'(b_md), 32'(nout + 1));
        nout++;
      end
      if (b_sv && b_sr) nin++;
      cyc++;
      @(negedge clk);
    end
    chk("d1 transfers", 32'(nout), 32'd8);
    chk("d1 cycles", 32'(cyc), 32'd16);
    b_sv = 1'b0;

    // CNT_W=2 saturation while the head is held
    do_reset();
    b_mr = 1'b0; b_sv = 1'b1; b_sd = 8'h77;
    @(negedge clk);
    b_sv = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("sat stall%0d", k), 32'(b_stall), 32'(exp_stall3[k]));
      chk($sformatf("sat hold%0d", k), 32'(b_md), 32'h77);
    end
    do_reset();
    #1;
    chk("sat stall after rst", 32'(b_stall), 32'd0);
    chk("sat m_valid after rst", 32'(b_mv), 32'd0);

    // DEPTH=3 random traffic against a queue model
    do_reset();
    q.delete();
    mstall = 0;
    for (int i = 0; i < 120; i++) begin
      c_sv = 1'($urandom_range(0, 1));
      c_sd = 8'($urandom);
      c_mr = 1'($urandom_range(0, 1));
      c_flush = ($urandom_range(0, 19) == 0);
      #1;
      exp_sr = (q.size() < 3) && !c_flush;
      exp_mv = (q.size() != 0);
      chk($sformatf("r%0d s_ready", i), 32'(c_sr), 32'(exp_sr));
      chk($sformatf("r%0d m_valid", i), 32'(c_mv), 32'(exp_mv));
      chk($sformatf("r%0d count", i), 32'(c_cnt), 32'(q.size()));
      chk($sformatf("r%0d stall_cnt", i), 32'(c_stall), 32'(mstall));
      if (exp_mv) chk($sformatf("r%0d m_data", i), 32'(c_md), 32'(q[0]));
      if (exp_mv && !c_mr && mstall < 65535) mstall++;
      if (c_flush) q.delete();
      else begin
        if (exp_mv && c_mr) void'(q.pop_front());
        if (c_sv && exp_sr) q.push_back(c_sd);
      end
      @(negedge clk);
    end
    c_sv = 1'b0; c_mr = 1'b0; c_flush = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter: WIDTH, default 32, payload width in bits; legal range 1..256.
REQ-002 Parameter: DEPTH, default 2, number of buffered entries; legal range 1..4.
REQ-003 Parameter: CNT_W, default 16, width of stall statistics counter; legal range 1..32.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 s_valid  input  1  upstream payload valid.
REQ-008 s_ready  output  1  stage can accept a payload this cycle.
REQ-009 s_data  input  WIDTH  upstream payload.
REQ-010 m_valid  output  1  head payload valid toward downstream.
REQ-011 m_ready  input  1  downstream accepts head payload.
REQ-012 m_data  output  WIDTH  head payload.
REQ-013 count  output  3  number of occupied entries, 0..DEPTH.
REQ-014 stall_cnt  output  CNT_W  cycles with m_valid=1 and m_ready=0.

Function
REQ-015 Upstream transfer occurs in a cycle iff s_valid=1 and s_ready=1; downstream transfer occurs iff m_valid=1 and m_ready=1.
REQ-016 Storage is an in-order FIFO of DEPTH entries; payloads leave in acceptance order, none duplicated or dropped except by flush or rst.
REQ-017 s_ready = (count < DEPTH) and not flush; s_ready has no combinational dependence on m_ready, s_valid or s_data.
REQ-018 m_valid = (count != 0); m_data = head entry, driven from a register, with no combinational path from s_data or s_valid.
REQ-019 Latency: a payload accepted at edge N into an empty stage appears with m_valid=1 after edge N, i.e. visible in cycle N+1.
REQ-020 While m_valid=1 and m_ready=0, m_data and m_valid hold stable until the transfer occurs or flush/rst.
REQ-021 Simultaneous upstream and downstream transfer in one cycle leaves count unchanged; the new payload goes to the tail.
REQ-022 Throughput: DEPTH>=2 sustains one transfer per cycle with m_ready held 1; DEPTH=1 sustains one transfer per two cycles.
REQ-023 Full (count=DEPTH): s_ready=0 regardless of m_ready; a pop that cycle raises s_ready the next cycle.
REQ-024 Empty (count=0): m_valid=0, m_ready ignored, m_data value don't-care.
REQ-025 Read/write pointers wrap modulo DEPTH, including non-power-of-two DEPTH=3.
REQ-026 flush=1: after the edge, count=0 and m_valid=0; any s_valid that cycle is not transferred (s_ready=0); any m_ready handshake that cycle is still counted as completed by downstream but has no further effect.
REQ-027 flush takes priority over push and pop in the same cycle.
REQ-028 stall_cnt increments by 1 each cycle with m_valid=1 and m_ready=0, saturates at 2^CNT_W-1, and is not cleared by flush.

Reset
REQ-029 rst=1 at an edge: count=0, m_valid=0, pointers=0, stall_cnt=0; s_ready=0 while rst=1.
REQ-030 rst takes priority over flush, push and pop; rst asserted mid-operation discards all entries.
REQ-031 First transfer is possible in the first cycle after rst deasserts; m_data contents after reset are unspecified but m_valid=0.

Verification
REQ-032 DEPTH=2: rst, then push 0xA1,0xA2,0xA3 on consecutive cycles with m_ready=1 -> outputs 0xA1,0xA2,0xA3 on consecutive cycles, each one cycle after acceptance, count never exceeds 1.
REQ-033 DEPTH=2: m_ready=0, push 0x11,0x12,0x13 -> 0x11,0x12 accepted, s_ready=0 on third, count=2, m_data held 0x11; stall_cnt=2 after two held cycles with m_valid=1; raise m_ready -> 0x11,0x12,0x13 emerge in order.
REQ-034 DEPTH=1: continuous s_valid and m_ready=1 with payloads 1..8 -> 8 transfers take 16 cycles, order preserved.
REQ-035 DEPTH=3: 20 random push/pop cycles causing pointer wrap -> scoreboard matches, count tracks occupancy exactly.
REQ-036 count=2, flush=1 with s_valid=1 and data 0x55 -> next cycle count=0, m_valid=0, 0x55 never emitted; stall_cnt unchanged.
REQ-037 CNT_W=2, m_valid held with m_ready=0 for 6 cycles -> stall_cnt sequence 1,2,3,3,3,3; rst -> 0.
